// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the "110" sequence detector.
// Words arrive over valid/ready; a one-word holding register keeps back-to-back words gap-free.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   sreg_r, sreg_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [WIDTH-1:0]   hold_r, hold_s;
  logic               hold_full_r, hold_full_s;
  logic               accept_s;
  logic               bit_out_r, bit_out_s;
  logic               bit_valid_r, bit_valid_s;
  logic               first_bit_r, first_bit_s;
  logic               busy_r, busy_s;

  // Move the register one position toward the output end; the vacated bit is don't-care fill.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  function automatic logic out_end(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Ready is forced low while reset is held so nothing is accepted into a resetting block.
  assign data_ready = rst & ~hold_full_r;
  assign accept_s   = data_valid & data_ready;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s     = state_r;
    sreg_s      = sreg_r;
    cnt_s       = cnt_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    case (state_r)
      IDLE: begin
        hold_full_s = 1'b0;
        if (accept_s) begin
          sreg_s  = data_in;
          cnt_s   = '0;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r != LAST) begin
          sreg_s = shift_word(sreg_r);
          cnt_s  = cnt_r + CW'(1);
          if (accept_s) begin
            hold_s      = data_in;
            hold_full_s = 1'b1;
          end else begin
            hold_full_s = hold_full_r;
          end
        end else if (hold_full_r) begin
          sreg_s      = hold_r;
          hold_full_s = 1'b0;
          cnt_s       = '0;
        end else if (accept_s) begin
          // Last-bit edge with an empty hold: load straight from the input, no idle bit.
          sreg_s = data_in;
          cnt_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s     = IDLE;
        hold_full_s = 1'b0;
      end
    endcase

    if (state_s == SHIFT) begin
      bit_out_s = out_end(sreg_s);
    end else begin
      bit_out_s = IDLE_BIT;
    end
    bit_valid_s = (state_s == SHIFT);
    first_bit_s = (state_s == SHIFT) && (cnt_s == '0);
    busy_s      = (state_s == SHIFT) || hold_full_s;
  end

  // State, datapath and output registers; reset discards any partial or held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      sreg_r      <= '0;
      cnt_r       <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      bit_out_r   <= IDLE_BIT;
      bit_valid_r <= 1'b0;
      first_bit_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      sreg_r      <= sreg_s;
      cnt_r       <= cnt_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      bit_out_r   <= bit_out_s;
      bit_valid_r <= bit_valid_s;
      first_bit_r <= first_bit_s;
      busy_r      <= busy_s;
    end
  end

  assign bit_out   = bit_out_r;
  assign bit_valid = bit_valid_r;
  assign first_bit = first_bit_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed and randomized-handshake bench for seq_bit_serializer (WIDTH=8).
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, bit_out, bit_valid, first_bit, busy;
  logic [7:0] d2_in = 8'h00;
  logic       d2_valid = 1'b0;
  logic       d2_ready, b2_out, b2_valid, f2_bit, busy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .first_bit(first_bit), .busy(busy)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(d2_in), .data_valid(d2_valid),
    .data_ready(d2_ready), .bit_out(b2_out), .bit_valid(b2_valid),
    .first_bit(f2_bit), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit_out"},   32'(bit_out),    32'd0);
    check({tag, "_bit_valid"}, 32'(bit_valid),  32'd0);
    check({tag, "_first_bit"}, 32'(first_bit),  32'd0);
    check({tag, "_busy"},      32'(busy),       32'd0);
    check({tag, "_ready"},     32'(data_ready), 32'd0);
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] w2;
    logic [7:0]  expq[$];
    bit          bitq[$];
    int          acc_n;
    int          cyc;
    int          guard;
    logic [7:0]  rebuilt;

    // Reset state
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_release", 32'(data_ready), 32'd1);

    // Single word C3
    w = 8'hC3;
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = w;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 9) begin
        check($sformatf("c3_bit%0d", c - 2), 32'(bit_out), 32'(w[9 - c]));
        check($sformatf("c3_valid%0d", c - 2), 32'(bit_valid), 32'd1);
        check($sformatf("c3_first%0d", c - 2), 32'(first_bit), 32'(c == 2));
      end else begin
        check("c3_idle_bit", 32'(bit_out), 32'd0);
        check("c3_idle_valid", 32'(bit_valid), 32'd0);
        check("c3_idle_busy", 32'(busy), 32'd0);
      end
      if (c == 2) begin
        data_valid = 1'b0;
        data_in    = 8'h5A;
      end
    end

    // Back-to-back D0 then 06
    w2 = 16'hD006;
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = 8'hD0;
    for (int c = 2; c <= 18; c++) begin
      @(negedge clk);
      if (c <= 17) begin
        check($sformatf("b2b_bit%0d", c - 2), 32'(bit_out), 32'(w2[17 - c]));
        check($sformatf("b2b_valid%0d", c - 2), 32'(bit_valid), 32'd1);
        check($sformatf("b2b_first%0d", c - 2), 32'(first_bit), 32'((c == 2) || (c == 10)));
      end else begin
        check("b2b_end_valid", 32'(bit_valid), 32'd0);
      end
      if (c <= 10) begin
        check($sformatf("b2b_ready_c%0d", c), 32'(data_ready), 32'(!((c >= 3) && (c <= 9))));
      end
      if (c == 2) data_in = 8'h06;
      if (c == 3) data_valid = 1'b0;
    end

    // Reset during bit 4 of FF with AA held
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = 8'hFF;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) data_in = 8'hAA;
      if (c == 3) begin
        data_valid = 1'b0;
        check("rst_hold_ready", 32'(data_ready), 32'd0);
        check("rst_hold_busy", 32'(busy), 32'd1);
      end
    end
    check("rst_pre_bit4", 32'(bit_out), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midword");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midword_release_ready", 32'(data_ready), 32'd1);
    check("midword_release_busy", 32'(busy), 32'd0);
    w = 8'h81;
    data_valid = 1'b1;
    data_in    = w;
    bitq.delete();
    guard = 0;
    do begin
      @(negedge clk);
      data_valid = 1'b0;
      if (bit_valid) bitq.push_back(bit_out);
      guard++;
    end while ((busy || bitq.size() == 0) && guard < 40);
    check("post_rst_len", 32'(bitq.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < bitq.size()) check($sformatf("post_rst_bit%0d", k), 32'(bitq[k]), 32'(w[7 - k]));
    end

    // LSB-first instance, word 01
    w = 8'h01;
    @(negedge clk);
    d2_valid = 1'b1;
    d2_in    = w;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("lsb_bit%0d", c - 2), 32'(b2_out), 32'(w[c - 2]));
      check($sformatf("lsb_valid%0d", c - 2), 32'(b2_valid), 32'd1);
      if (c == 2) d2_valid = 1'b0;
    end

    // Random valid against ready for 200 words
    bitq.delete();
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bit_valid) bitq.push_back(bit_out);
      data_valid = ($urandom_range(0, 2) != 0);
      data_in    = 8'($urandom);
      #1;
      if (data_valid && data_ready) begin
        expq.push_back(data_in);
        acc_n++;
      end
    end
    check("rand_accept_count", 32'(acc_n), 32'd200);
    @(negedge clk);
    if (bit_valid) bitq.push_back(bit_out);
    data_valid = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      if (bit_valid) bitq.push_back(bit_out);
      guard++;
    end
    check("rand_drained", 32'(busy), 32'd0);
    check("rand_stream_len", 32'(bitq.size()), 32'(8 * expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (8 * i + 7 < bitq.size()) begin
        for (int k = 0; k < 8; k++) rebuilt[7 - k] = bitq[8 * i + k];
        check($sformatf("rand_word%0d", i), 32'(rebuilt), 32'(expq[i]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
